// File: rtl/mp_alu_pkg.sv
// mp_alu_pkg: shared ALU command codes, sequencer states and widths.
package mp_alu_pkg;
    localparam int ALU_CMD_W = 4;
    localparam int DATA_W = 8;
    typedef enum logic [ALU_CMD_W-1:0] {
        OP_AND = 4'b0000, OP_XOR, OP_OR, OP_SHL, OP_SHR, OP_ADD, OP_SUB, OP_PASS
    } alu_op_t;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_FIN} seq_state_t;
    function automatic logic is_arith(input logic [ALU_CMD_W-1:0] o);
        return o == OP_ADD || o == OP_SUB || o == OP_SHL || o == OP_SHR;
    endfunction
endpackage

// File: rtl/mp_alu_seq_addr.sv
// mp_alu_seq_addr: byte-index counter and wrapping address generator.
module mp_alu_seq_addr #(
    parameter int NREGS = 16,
    parameter int AW = $clog2(NREGS),
    parameter int LW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic          rev,
    input  logic [LW-1:0] len,
    input  logic [AW-1:0] a_base,
    input  logic [AW-1:0] b_base,
    input  logic [AW-1:0] d_base,
    output logic [AW-1:0] raddr_a,
    output logic [AW-1:0] raddr_b,
    output logic [AW-1:0] waddr,
    output logic          last
);
    logic [LW-1:0] idx, len_q;
    logic          rev_q;
    logic [AW-1:0] a_q, b_q, d_q;
    function automatic logic [AW-1:0] wrap(input logic [AW-1:0] base, input logic [LW-1:0] i);
        return AW'((32'(base) + 32'(i)) % NREGS);
    endfunction
    // len of zero wraps to the full MAXLEN bytes through modular index arithmetic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            len_q <= '0;
            rev_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            d_q <= '0;
        end else if (load) begin
            idx <= rev ? len - LW'(1) : '0;
            len_q <= len;
            rev_q <= rev;
            a_q <= a_base;
            b_q <= b_base;
            d_q <= d_base;
        end else if (step) begin
            idx <= rev_q ? idx - LW'(1) : idx + LW'(1);
        end
    end
    assign raddr_a = wrap(a_q, idx);
    assign raddr_b = wrap(b_q, idx);
    assign waddr = wrap(d_q, idx);
    assign last = idx == (rev_q ? '0 : len_q - LW'(1));
endmodule

// File: rtl/mp_alu_seq.sv
// mp_alu_seq: byte-serial multi-precision ALU sequencer over an external register file and ALU.
// Define MP_ALU_SEQ_FLAGS_EN to enable carry/zero flag tracking; otherwise both flags read 0.
module mp_alu_seq
    import mp_alu_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int MAXLEN = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ALU_CMD_W-1:0]         op,
    input  logic [$clog2(MAXLEN)-1:0]    len,
    input  logic [$clog2(NREGS)-1:0]     a_base,
    input  logic [$clog2(NREGS)-1:0]     b_base,
    input  logic [$clog2(NREGS)-1:0]     d_base,
    output logic                         busy,
    output logic                         done,
    output logic                         carry_flag,
    output logic                         zero_flag,
    output logic [$clog2(NREGS)-1:0]     rf_raddr_a,
    output logic [$clog2(NREGS)-1:0]     rf_raddr_b,
    input  logic [DATA_W-1:0]            rf_rdata_a,
    input  logic [DATA_W-1:0]            rf_rdata_b,
    output logic                         rf_we,
    output logic [$clog2(NREGS)-1:0]     rf_waddr,
    output logic [DATA_W-1:0]            rf_wdata,
    output logic [ALU_CMD_W-1:0]         alu_command,
    output logic [DATA_W-1:0]            alu_a,
    output logic [DATA_W-1:0]            alu_b,
    output logic                         alu_cin,
    input  logic [DATA_W-1:0]            alu_result,
    input  logic                         alu_cout
);
    localparam int AW = $clog2(NREGS);
    localparam int LW = $clog2(MAXLEN);
    seq_state_t           state, nxt;
    logic [ALU_CMD_W-1:0] op_q;
    logic                 carry, last, accept, exec, sub;
    assign accept = state == S_IDLE && start;
    assign exec = state == S_EXEC;
    assign sub = op_q == OP_SUB;
    mp_alu_seq_addr #(.NREGS(NREGS), .AW(AW), .LW(LW)) u_addr (
        .clk(clk), .rst_n(rst_n), .load(accept), .step(exec), .rev(op == OP_SHR),
        .len(len), .a_base(a_base), .b_base(b_base), .d_base(d_base),
        .raddr_a(rf_raddr_a), .raddr_b(rf_raddr_b), .waddr(rf_waddr), .last(last)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else state <= nxt;
    end
    // op codes with the top bit set are illegal and go straight to FIN
    always_comb begin
        nxt = state == S_IDLE ? (start ? (op[3] ? S_FIN : S_EXEC) : S_IDLE) :
              state == S_EXEC ? (last ? S_FIN : S_EXEC) : S_IDLE;
    end
    always_comb begin
        busy = state != S_IDLE;
        done = state == S_FIN;
        rf_we = exec;
        rf_wdata = alu_result;
        alu_command = exec ? (sub ? ALU_CMD_W'(OP_ADD) : op_q) : '0;
        alu_a = exec ? rf_rdata_a : '0;
        alu_b = exec ? (sub ? ~rf_rdata_b : rf_rdata_b) : '0;
        alu_cin = exec && is_arith(op_q) && carry;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
            carry <= 1'b0;
        end else if (accept) begin
            op_q <= op;
            carry <= op == OP_SUB;
        end else if (exec && is_arith(op_q)) begin
            carry <= alu_cout;
        end
    end
`ifdef MP_ALU_SEQ_FLAGS_EN
    logic zacc;
    // flags are captured on the last byte so they are already valid while done is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_flag <= 1'b0;
            zero_flag <= 1'b0;
            zacc <= 1'b1;
        end else begin
            if (accept) zacc <= 1'b1;
            else if (exec) zacc <= zacc && alu_result == '0;
            if (exec && last) begin
                zero_flag <= zacc && alu_result == '0;
                if (is_arith(op_q)) carry_flag <= alu_cout;
            end
        end
    end
`else
    assign carry_flag = 1'b0;
    assign zero_flag = 1'b0;
`endif
endmodule

// File: tb/tb_mp_alu_seq.sv
// tb_mp_alu_seq: directed self-checking bench with a register-file and ALU model around mp_alu_seq.
module tb_mp_alu_seq;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [3:0] op = '0, a_base = '0, b_base = '0, d_base = '0;
    logic [2:0] len = '0;
    logic       busy, done, carry_flag, zero_flag, rf_we, alu_cin, alu_cout;
    logic [3:0] rf_raddr_a, rf_raddr_b, rf_waddr, alu_command;
    logic [7:0] rf_rdata_a, rf_rdata_b, rf_wdata, alu_a, alu_b, alu_result;
    logic [7:0] rf [16];
    logic [11:0] wq [$];
    logic       ld_en = 1'b0;
    logic [3:0] ld_a = '0;
    logic [7:0] ld_d = '0;
    int         checks = 0, errors = 0, cyc;
`ifdef MP_ALU_SEQ_FLAGS_EN
    localparam logic FL = 1'b1;
`else
    localparam logic FL = 1'b0;
`endif

    mp_alu_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .len(len),
        .a_base(a_base), .b_base(b_base), .d_base(d_base),
        .busy(busy), .done(done), .carry_flag(carry_flag), .zero_flag(zero_flag),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_command(alu_command), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout)
    );

    always #5 clk = ~clk;

    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];

    always @(posedge clk) begin
        if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
            wq.push_back({rf_waddr, rf_wdata});
        end else if (ld_en) begin
            rf[ld_a] <= ld_d;
        end
    end

    always_comb begin
        alu_result = 8'h00;
        alu_cout = 1'b0;
        case (alu_command)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a ^ alu_b;
            4'b0010: alu_result = alu_a | alu_b;
            4'b0011: {alu_cout, alu_result} = {alu_a, alu_cin};
            4'b0100: {alu_result, alu_cout} = {alu_cin, alu_a};
            4'b0101: {alu_cout, alu_result} = 9'(alu_a) + 9'(alu_b) + 9'(alu_cin);
            4'b0111: alu_result = alu_a;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ld(input logic [3:0] a, input logic [7:0] d);
        ld_en = 1'b1;
        ld_a = a;
        ld_d = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic go(input logic [3:0] o, input logic [2:0] l, input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
        op = o;
        len = l;
        a_base = a;
        b_base = b;
        d_base = d;
        start = 1'b1;
        wq.delete();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 1;
        while (done !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        @(negedge clk);
        ld(4'd0, 8'h01); ld(4'd1, 8'hFF); ld(4'd2, 8'h00); ld(4'd3, 8'h01);
        ld(4'd4, 8'h05); ld(4'd5, 8'h05); ld(4'd6, 8'h00); ld(4'd7, 8'h01);
        ld(4'd13, 8'h00); ld(4'd15, 8'h5A);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", rf_we, 0);
        chk("rst_cmd", alu_command, 0);
        chk("rst_flags", {carry_flag, zero_flag}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        go(4'b0101, 3'd2, 4'd0, 4'd2, 4'd8);
        chk("add_c1_we", rf_we, 1);
        wait_done(cyc);
        chk("add_done_cycle", cyc, 3);
        chk("add_nwr", wq.size(), 2);
        chk("add_wr0", wq[0], {4'd8, 8'h01});
        chk("add_wr1", wq[1], {4'd9, 8'h00});
        chk("add_flags", {carry_flag, zero_flag}, {FL, 1'b0});
        @(negedge clk);
        chk("add_idle_busy", busy, 0);
        chk("idle_alu", {alu_command, alu_a, alu_b, alu_cin}, 0);

        go(4'b0110, 3'd1, 4'd4, 4'd5, 4'd10);
        chk("sub_cmd", alu_command, 4'b0101);
        chk("sub_alu_b", alu_b, 8'hFA);
        chk("sub_cin", alu_cin, 1);
        wait_done(cyc);
        chk("sub_done_cycle", cyc, 2);
        chk("sub_wr0", wq[0], {4'd10, 8'h00});
        chk("sub_flags", {carry_flag, zero_flag}, {FL, FL});
        @(negedge clk);

        go(4'b1010, 3'd2, 4'd0, 4'd0, 4'd0);
        chk("ill_we", rf_we, 0);
        wait_done(cyc);
        chk("ill_done_cycle", cyc, 1);
        @(negedge clk);
        chk("ill_nwr", wq.size(), 0);
        chk("ill_flags", {carry_flag, zero_flag}, {FL, FL});

        go(4'b0100, 3'd2, 4'd6, 4'd6, 4'd11);
        chk("shr_raddr0", rf_raddr_a, 4'd7);
        wait_done(cyc);
        chk("shr_done_cycle", cyc, 3);
        chk("shr_wr0", wq[0], {4'd12, 8'h00});
        chk("shr_wr1", wq[1], {4'd11, 8'h80});
        chk("shr_flags", {carry_flag, zero_flag}, 2'b00);
        @(negedge clk);

        go(4'b0111, 3'd3, 4'd15, 4'd15, 4'd12);
        chk("wrap_raddr0", rf_raddr_a, 4'hF);
        chk("wrap_cin", alu_cin, 0);
        @(negedge clk);
        chk("wrap_raddr1", rf_raddr_a, 4'h0);
        op = 4'b0101;
        len = 3'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("wrap_raddr2", rf_raddr_a, 4'h1);
        wait_done(cyc);
        chk("wrap_done_step", cyc, 2);
        chk("wrap_nwr", wq.size(), 3);
        chk("wrap_wr0", wq[0], {4'd12, 8'h5A});
        chk("wrap_wr1", wq[1], {4'd13, 8'h01});
        chk("wrap_wr2", wq[2], {4'd14, 8'hFF});
        chk("wrap_flags", {carry_flag, zero_flag}, 2'b00);
        @(negedge clk);
        chk("nq_busy0", busy, 0);
        @(negedge clk);
        chk("nq_busy1", busy, 0);

        go(4'b0101, 3'd2, 4'd13, 4'd13, 4'd14);
        wait_done(cyc);
        chk("ovl_wr0", wq[0], {4'd14, 8'h02});
        chk("ovl_wr1", wq[1], {4'd15, 8'h04});
        @(negedge clk);

        go(4'b0101, 3'd0, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_we", rf_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_flags", {carry_flag, zero_flag}, 0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_nwr", wq.size(), 1);
        chk("abort_wr0", wq[0], {4'd0, 8'h02});
        rst_n = 1'b1;
        go(4'b0001, 3'd1, 4'd3, 4'd2, 4'd13);
        chk("rec_busy", busy, 1);
        chk("rec_we", rf_we, 1);
        wait_done(cyc);
        chk("rec_done_cycle", cyc, 2);
        chk("rec_wr0", wq[0], {4'd13, 8'h01});
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mp_alu_seq.md
MP_ALU_SEQ -- requirements
Module: mp_alu_seq

Interface
REQ-001 The block SHALL have parameter NREGS, default 16, giving the register-file depth; address width is clog2(NREGS).
REQ-002 The block SHALL have parameter MAXLEN, default 8, giving the maximum operand length in bytes.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  4  operation: 0000 AND, 0001 XOR, 0010 OR, 0011 SHL, 0100 SHR, 0101 ADD, 0110 SUB, 0111 PASS.
- len  in  3  byte count; 3'd0 means 8.
- a_base, b_base, d_base  in  4 each  LSB register address of A, B and destination.
- busy  out  1  an operation is in progress.
- done  out  1  one-cycle completion pulse.
- carry_flag, zero_flag  out  1 each  result flags.
- rf_raddr_a, rf_raddr_b  out  4 each  register-file read addresses (combinational read).
- rf_rdata_a, rf_rdata_b  in  8 each  register-file read data.
- rf_we  out  1  write enable; rf_waddr  out  4  write address; rf_wdata  out  8  write data.
- alu_command  out  4  ALU command; alu_a, alu_b  out  8 each  ALU operands; alu_cin  out  1  ALU carry-in.
- alu_result  in  8  ALU result; alu_cout  in  1  ALU carry-out.

Function
REQ-004 The block SHALL implement the FSM states IDLE, EXEC and FIN, with transitions IDLE->EXEC on start and a legal op, IDLE->FIN on start and an op >= 1000, EXEC->FIN after the last byte, and FIN->IDLE unconditionally.
REQ-005 The block SHALL latch op, len, the base addresses and the byte index at the start edge; input changes while busy SHALL be ignored.
REQ-006 The block SHALL process one byte per EXEC cycle: the addresses for byte i drive the read ports, the read data drives the ALU, and the ALU result is written the same cycle with rf_we=1.
REQ-007 The block SHALL compute the address of byte i as (base + i) mod NREGS, so address wrap-around is legal.
REQ-008 For AND, XOR, OR, PASS, SHL, ADD and SUB the block SHALL process bytes in order i = 0..len-1 (LSB first); for SHR it SHALL process bytes in order len-1..0 (MSB first).
REQ-009 The block SHALL hold the carry chain in a register: initial value 0 for ADD, SHL and SHR, initial value 1 for SUB, and updated from alu_cout after each byte.
REQ-010 For SUB the block SHALL issue alu_command=0101 with alu_b = ~rf_rdata_b (two's-complement chain); for every other op, alu_command SHALL equal op.
REQ-011 For logical ops and PASS the block SHALL drive alu_cin=0 and SHALL leave the carry register unchanged.
REQ-012 Latency: with start sampled at edge 0, the block SHALL write bytes on cycles 1..len and pulse done on cycle len+1.
REQ-013 busy SHALL be 1 in EXEC and FIN; done SHALL be 1 only in FIN.
REQ-014 A start asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-015 Overlapping source and destination ranges SHALL use sequential semantics: a read of byte i returns any value written by an earlier byte of the same operation.
REQ-016 An illegal op SHALL produce no writes, a done pulse on cycle 1, and unchanged flags.
REQ-017 Outside EXEC, the block SHALL drive rf_we=0 and SHALL drive alu_command, alu_a, alu_b and alu_cin to 0.

Reset
REQ-018 Asserting rst_n low SHALL immediately force IDLE, busy=0, done=0, rf_we=0 and carry_flag=0 and zero_flag=0, including mid-operation; no further writes of the aborted operation SHALL occur.
REQ-019 After rst_n deasserts, the first start SHALL be accepted on the first clock edge.

Configuration
REQ-020 When MP_ALU_SEQ_FLAGS_EN is defined, the block SHALL update both flags at FIN:
- carry_flag SHALL equal the final carry register for ADD, SUB, SHL and SHR, and SHALL be unchanged otherwise;
- zero_flag SHALL be 1 when all written bytes were 0x00.
REQ-021 When MP_ALU_SEQ_FLAGS_EN is not defined, both flags SHALL be tied to 0 and no flag logic SHALL be present.

Structure
REQ-022 The shared package mp_alu_pkg SHALL hold the alu_op_t enum (the 4-bit command codes), the seq_state_t enum, and the constants ALU_CMD_W=4 and DATA_W=8.
REQ-023 The block SHALL contain one sub-module, mp_alu_seq_addr, a byte-index counter plus address generator (direction, wrap, last-byte detect); the ALU itself SHALL be instantiated outside this block.

Verification
REQ-024 The bench SHALL cover ADD with len=2, A={0x01,0xFF}, B={0x00,0x01} (LSB first) -> writes 0x01 then 0x00, carry_flag=1, done on cycle 3.
REQ-025 The bench SHALL cover SUB with len=1, A=0x05, B=0x05 -> write 0x00, alu_b=0xFA with alu_cin=1, carry_flag=1, zero_flag=1.
REQ-026 The bench SHALL cover SHR with len=2, A={0x00,0x01} -> write order: byte1 0x00 first, then byte0 0x80; carry_flag=0.
REQ-027 The bench SHALL cover a_base=0xF, len=3 -> reads from addresses 0xF, 0x0, 0x1; start pulsed during EXEC -> ignored.
REQ-028 The bench SHALL cover op=1010 -> no rf_we, done on cycle 1, flags unchanged.
REQ-029 The bench SHALL cover rst_n low on cycle 2 of a len=8 ADD -> rf_we falls immediately, no further writes, busy=0.
